// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler sharing one I2C byte-level master between NREQ requesters.
// Sequences start/address/data/stop on the master, returns per-byte status, aborts stalled transfers.
module i2c_txn_scheduler #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned LENW        = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rd_wr,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [LENW*NREQ-1:0] req_len,
    input  logic [8*NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic                 wr_ack,
    output logic                 rd_valid,
    output logic [7:0]           rd_data,
    output logic                 done,
    output logic                 err,
    output logic                 m_start,
    output logic                 m_stop,
    output logic                 m_rd_wr,
    output logic [6:0]           m_address,
    output logic [7:0]           m_din,
    input  logic                 m_byte_done,
    input  logic                 m_nack,
    input  logic [7:0]           m_dout,
    input  logic                 m_idle
);

    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WDW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_START, S_WADDR, S_DATA, S_STOP, S_DONE
    } state_t;

    state_t            state, state_next;
    logic [PW-1:0]     rr_ptr, win, pick;
    logic [LENW-1:0]   byte_cnt, cnt_next;
    logic              err_lat, err_next;
    logic              wr_ack_next, rd_valid_next;
    logic [WDW-1:0]    wdog;
    logic              timeout, watched, arb_load;

    logic [6:0]        addr_arr  [NREQ];
    logic [LENW-1:0]   len_arr   [NREQ];
    logic [7:0]        wdata_arr [NREQ];

    // Unpack the flat per-requester buses.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            addr_arr[i]  = req_addr[7*i +: 7];
            len_arr[i]   = req_len[LENW*i +: LENW];
            wdata_arr[i] = req_wdata[8*i +: 8];
        end
    end

    // First set request at or above rr_ptr, wrapping.
    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = PW'((32'(rr_ptr) + 32'(i)) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign timeout  = (wdog == WDW'(TIMEOUT_CYC - 1));
    assign watched  = (state == S_WADDR) || (state == S_DATA) || (state == S_STOP);
    assign arb_load = (state == S_IDLE) && (state_next == S_ARB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        err_next      = err_lat;
        cnt_next      = byte_cnt;
        wr_ack_next   = 1'b0;
        rd_valid_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req && m_idle) begin
                    state_next = S_ARB;
                    err_next   = 1'b0;
                    cnt_next   = (len_arr[pick] == '0) ? LENW'(1) : len_arr[pick];
                end
            end
            S_ARB:   state_next = S_START;
            S_START: state_next = S_WADDR;
            S_WADDR: begin
                if (m_byte_done) begin
                    state_next = m_nack ? S_STOP : S_DATA;
                    err_next   = m_nack;
                end else if (timeout) begin
                    state_next = S_STOP;
                    err_next   = 1'b1;
                end
            end
            S_DATA: begin
                if (m_byte_done) begin
                    if (m_rd_wr && m_nack) begin
                        state_next = S_STOP;
                        err_next   = 1'b1;
                    end else begin
                        wr_ack_next   = m_rd_wr;
                        rd_valid_next = !m_rd_wr;
                        if (byte_cnt != '0) cnt_next = byte_cnt - LENW'(1);
                        if (byte_cnt <= LENW'(1)) state_next = S_STOP;
                    end
                end else if (timeout) begin
                    state_next = S_STOP;
                    err_next   = 1'b1;
                end
            end
            S_STOP: begin
                if (m_idle) begin
                    state_next = S_DONE;
                end else if (timeout) begin
                    state_next = S_DONE;
                    err_next   = 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            win       <= '0;
            byte_cnt  <= '0;
            err_lat   <= 1'b0;
            wdog      <= '0;
            gnt       <= '0;
            wr_ack    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            m_start   <= 1'b0;
            m_stop    <= 1'b0;
            m_rd_wr   <= 1'b0;
            m_address <= '0;
            m_din     <= '0;
        end else begin
            byte_cnt <= cnt_next;
            err_lat  <= err_next;
            wr_ack   <= wr_ack_next;
            rd_valid <= rd_valid_next;
            done     <= (state_next == S_DONE);
            err      <= (state_next == S_DONE) && err_next;
            m_start  <= (state_next == S_START);
            m_stop   <= (state_next == S_STOP);
            if (rd_valid_next) rd_data <= m_dout;

            if (arb_load) begin
                win       <= pick;
                gnt       <= NREQ'(1) << pick;
                m_rd_wr   <= req_rd_wr[pick];
                m_address <= addr_arr[pick];
            end else if (state_next == S_IDLE) begin
                gnt <= '0;
            end

            // Write data follows the winner's current byte for the whole transfer.
            if (state != S_IDLE && m_rd_wr) m_din <= wdata_arr[win];

            if (state == S_DONE)
                rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

            if (state_next != state || m_byte_done || !watched) wdog <= '0;
            else if (!timeout)                                 wdog <= wdog + WDW'(1);
        end
    end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler with a behavioural byte-level master.
module tb_i2c_txn_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LENW = 4;
    localparam int unsigned TO   = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0, req_rd_wr = '0;
    logic [27:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  gnt;
    logic        wr_ack, rd_valid, done, err, m_start, m_stop, m_rd_wr;
    logic [7:0]  rd_data, m_din;
    logic [6:0]  m_address;
    logic        m_byte_done = 1'b0, m_nack = 1'b0, m_idle = 1'b1;
    logic [7:0]  m_dout = '0;

    i2c_txn_scheduler #(.NREQ(NREQ), .LENW(LENW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rd_wr(req_rd_wr),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .gnt(gnt), .wr_ack(wr_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .err(err), .m_start(m_start), .m_stop(m_stop),
        .m_rd_wr(m_rd_wr), .m_address(m_address), .m_din(m_din),
        .m_byte_done(m_byte_done), .m_nack(m_nack), .m_dout(m_dout), .m_idle(m_idle)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int n_wrack = 0, n_rd = 0, n_done = 0, n_start = 0, n_stop = 0;
    logic last_err = 1'b0, m_stop_q = 1'b0;
    logic [7:0] rd_q[$], wd_q[$];
    int stop_wait = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Event monitor on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_ack)   begin n_wrack++; wd_q.push_back(m_din); end
            if (rd_valid) begin n_rd++; rd_q.push_back(rd_data); end
            if (done)     begin n_done++; last_err = err; end
            if (m_start)  n_start++;
            if (m_stop && !m_stop_q) n_stop++;
        end
        m_stop_q = m_stop;
    end

    // Master bus-idle model: busy after start, idle again two cycles into a stop.
    always @(negedge clk) begin
        if (reset) begin
            m_idle = 1'b1;
            stop_wait = 0;
        end else if (m_start) begin
            m_idle = 1'b0;
        end else if (m_stop && !m_idle) begin
            stop_wait++;
            if (stop_wait == 2) begin
                m_idle = 1'b1;
                stop_wait = 0;
            end
        end
    end

    task automatic master_byte(input logic nack, input logic [7:0] d);
        repeat (3) tick();
        m_dout = d;
        m_nack = nack;
        m_byte_done = 1'b1;
        tick();
        m_byte_done = 1'b0;
        m_nack = 1'b0;
    endtask

    task automatic wait_start(input int target);
        for (int i = 0; i < 100 && n_start < target; i++) tick();
        check("start_wait", 64'(n_start), 64'(target));
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && n_done < target; i++) tick();
        check("done_wait", 64'(n_done), 64'(target));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({gnt, wr_ack, rd_valid, rd_data, done, err, m_start, m_stop,
                    m_rd_wr, m_address, m_din});
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("reset_outs", all_outs(), 64'd0);
        reset = 1'b0;
        tick();

        // Write to 0x50 from requester 1, two bytes.
        req_rd_wr[1] = 1'b1; req_addr[13:7] = 7'h50; req_len[7:4] = 4'd2;
        req_wdata[15:8] = 8'hA5; req = 4'b0010;
        tick();
        check("arb_gnt", 64'(gnt), 64'h2);
        check("arb_no_start", 64'(m_start), 64'd0);
        tick();
        check("start_lat", 64'(m_start), 64'd1);
        check("w_addr", 64'(m_address), 64'h50);
        check("w_rdwr", 64'(m_rd_wr), 64'd1);
        req = 4'b0000;
        tick();
        check("start_pulse", 64'(m_start), 64'd0);
        master_byte(1'b0, 8'h00);
        master_byte(1'b0, 8'h00);
        req_wdata[15:8] = 8'h3C;
        master_byte(1'b0, 8'h00);
        wait_done(1);
        check("w_acks", 64'(n_wrack), 64'd2);
        check("w_byte0", 64'(wd_q[0]), 64'hA5);
        check("w_byte1", 64'(wd_q[1]), 64'h3C);
        check("w_err", 64'(last_err), 64'd0);
        check("w_stop", 64'(n_stop), 64'd1);
        tick();
        check("w_gnt_clr", 64'(gnt), 64'd0);

        // Read three bytes for requester 0.
        req_rd_wr[0] = 1'b0; req_addr[6:0] = 7'h2A; req_len[3:0] = 4'd3; req = 4'b0001;
        wait_start(2);
        check("r_gnt", 64'(gnt), 64'h1);
        check("r_addr", 64'(m_address), 64'h2A);
        check("r_rdwr", 64'(m_rd_wr), 64'd0);
        master_byte(1'b0, 8'h00);
        master_byte(1'b0, 8'h11);
        master_byte(1'b0, 8'h22);
        master_byte(1'b0, 8'h33);
        wait_done(2);
        req = 4'b0000;
        check("r_count", 64'(n_rd), 64'd3);
        check("r_byte0", 64'(rd_q[0]), 64'h11);
        check("r_byte1", 64'(rd_q[1]), 64'h22);
        check("r_byte2", 64'(rd_q[2]), 64'h33);
        check("r_err", 64'(last_err), 64'd0);
        check("r_no_wrack", 64'(n_wrack), 64'd2);

        // Address NACK from requester 2.
        req_rd_wr[2] = 1'b1; req_addr[20:14] = 7'h33; req_len[11:8] = 4'd1;
        req_wdata[23:16] = 8'h99; req = 4'b0100;
        wait_start(3);
        check("n_gnt", 64'(gnt), 64'h4);
        req = 4'b0000;
        master_byte(1'b1, 8'h00);
        wait_done(3);
        check("n_err", 64'(last_err), 64'd1);
        check("n_stop", 64'(n_stop), 64'd3);
        check("n_no_wrack", 64'(n_wrack), 64'd2);
        check("n_no_rd", 64'(n_rd), 64'd3);

        // Watchdog: master never reports a byte.
        req_len[7:4] = 4'd1; req = 4'b0010;
        wait_start(4);
        check("t_gnt", 64'(gnt), 64'h2);
        req = 4'b0000;
        repeat (32) tick();
        check("t_not_yet", 64'(m_stop), 64'd0);
        tick();
        check("t_stop", 64'(m_stop), 64'd1);
        wait_done(4);
        check("t_err", 64'(last_err), 64'd1);

        // Reset in the middle of a data phase from requester 3.
        req_rd_wr[3] = 1'b1; req_addr[27:21] = 7'h44; req_len[15:12] = 4'd2;
        req_wdata[31:24] = 8'hC3; req = 4'b1000;
        wait_start(5);
        check("x_gnt", 64'(gnt), 64'h8);
        master_byte(1'b0, 8'h00);
        tick();
        reset = 1'b1;
        #1;
        check("x_outs", all_outs(), 64'd0);
        req_rd_wr = '0; req_len = '0; req = 4'b1111;
        tick();
        tick();
        check("x_no_done", 64'(n_done), 64'd4);
        reset = 1'b0;

        // Round robin from pointer 0 after reset, single-byte reads (len 0).
        for (int k = 0; k < 5; k++) begin
            logic [3:0] eg;
            eg = 4'(1 << (k % 4));
            wait_start(6 + k);
            check("f_gnt", 64'(gnt), 64'(eg));
            if (k == 4) req = 4'b0000;
            master_byte(1'b0, 8'h00);
            master_byte(1'b0, 8'(8'h40 + k));
            wait_done(5 + k);
            check("f_rd_count", 64'(n_rd), 64'(4 + k));
            check("f_rd_data", 64'(rd_q[$]), 64'(8'h40 + k));
        end
        repeat (5) tick();
        check("f_quiet", 64'(n_start), 64'd10);
        check("f_gnt_clr", 64'(gnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
